// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
//   In-order DRAM command scheduler. Requests are buffered in a DEPTH-entry
//   FIFO and served one at a time through an ACT / CAS / PRE sequence with
//   TRCD, TCL+TBURST and TRP spacing.
//
//   Build option: define OPEN_PAGE_EN for open-page operation. In this mode
//   one open row is tracked per bank (16 banks, indexed by {bg,ba}). When the
//   macro is undefined, the block uses closed-page operation, where every
//   access ends with a PRE.
//
// Ports
//   clock, reset             sole clock; synchronous active-high reset
//   in_valid/in_command/     request input (0=read, 1=write, 2=ifetch,
//   in_address               others illegal), 36-bit byte address
//   in_done                  trace source exhausted (level)
//   full/empty/count         queue status (registered state only)
//   cmd_valid/dram_cmd       DRAM command (0=NOP 1=ACT 2=RD 3=WR 4=PRE)
//   dram_bg/ba/row/col       command address, held between commands
//   rsp_done                 one-cycle pulse per completed access
//   err_drop                 one-cycle pulse per illegal command discarded
//   drained                  in_done && empty && FSM idle
module dram_cmd_scheduler #(
  parameter int DEPTH  = 16,
  parameter int TRCD   = 24,
  parameter int TCL    = 24,
  parameter int TRP    = 24,
  parameter int TBURST = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_command,
  input  logic [35:0]              in_address,
  input  logic                     in_done,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     cmd_valid,
  output logic [2:0]               dram_cmd,
  output logic [1:0]               dram_bg,
  output logic [1:0]               dram_ba,
  output logic [14:0]              dram_row,
  output logic [9:0]               dram_col,
  output logic                     rsp_done,
  output logic                     err_drop,
  output logic                     drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Timer compare values: each wait state lasts (gap - 1) cycles because the
  // command state before it accounts for the first cycle of the gap.
  localparam logic [15:0] RCD_END  = 16'(TRCD - 2);
  localparam logic [15:0] DATA_END = 16'(TCL + TBURST - 2);
  localparam logic [15:0] RP_END   = 16'(TRP - 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACT, ST_WAIT_RCD, ST_CAS, ST_WAIT_DATA, ST_PRE, ST_WAIT_RP
  } state_t;

  state_t state, state_nx;
  logic [15:0] tmr;

  // ---------------- request queue ----------------
  // Entry layout: [29]=write, [28:27]=bg, [26:25]=ba, [24:10]=row, [9:0]=col
  logic [29:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          enq, deq;
  logic [29:0]   head;
  logic          unused_addr;

  assign unused_addr = ^{in_address[35:33], in_address[3:0]};

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  assign enq  = in_valid && !full && (in_command <= 32'd2);
  assign deq  = (state == ST_CAS);
  assign head = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (enq)
      mem[wr_ptr] <= {(in_command == 32'd1), in_address[7:6], in_address[17:16],
                      in_address[32:18], in_address[15:8], in_address[5:4]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      err_drop <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)      cnt <= cnt + 1'b1;
      else if (!enq && deq) cnt <= cnt - 1'b1;
      err_drop <= in_valid && (in_command > 32'd2);
    end
  end

`ifdef OPEN_PAGE_EN
  // ---------------- open-row tracking ----------------
  logic [15:0] bank_open;
  logic [14:0] open_row [16];
  logic [3:0]  head_bank;
  logic        row_hit;

  assign head_bank = head[28:25];
  assign row_hit   = bank_open[head_bank] && (open_row[head_bank] == head[24:10]);

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_open <= '0;
      for (int unsigned i = 0; i < 16; i++) open_row[i] <= '0;
    end else if (state == ST_ACT) begin
      bank_open[{dram_bg, dram_ba}] <= 1'b1;
      open_row[{dram_bg, dram_ba}]  <= dram_row;
    end else if (state == ST_PRE) begin
      bank_open[{dram_bg, dram_ba}] <= 1'b0;
    end
  end
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nx;
      tmr   <= (state_nx != state) ? '0 : tmr + 16'd1;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
`ifdef OPEN_PAGE_EN
          if (row_hit)                     state_nx = ST_CAS;
          else if (bank_open[head_bank])   state_nx = ST_PRE;
          else                             state_nx = ST_ACT;
`else
          state_nx = ST_ACT;
`endif
        end
      end
      ST_ACT:      state_nx = ST_WAIT_RCD;
      ST_WAIT_RCD: if (tmr == RCD_END) state_nx = ST_CAS;
      ST_CAS:      state_nx = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        if (tmr == DATA_END) begin
`ifdef OPEN_PAGE_EN
          state_nx = ST_IDLE;
`else
          state_nx = ST_PRE;
`endif
        end
      end
      ST_PRE:      state_nx = ST_WAIT_RP;
      ST_WAIT_RP: begin
        if (tmr == RP_END) begin
`ifdef OPEN_PAGE_EN
          state_nx = ST_ACT;
`else
          state_nx = ST_IDLE;
`endif
        end
      end
      default:     state_nx = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The head entry is latched into the address registers when the FSM leaves
  // IDLE; the head cannot change before CAS, and after the CAS dequeue the
  // latched copy keeps the closing PRE aimed at the bank just accessed.
  logic cur_wr;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_wr   <= 1'b0;
      dram_bg  <= '0;
      dram_ba  <= '0;
      dram_row <= '0;
      dram_col <= '0;
      rsp_done <= 1'b0;
    end else begin
      if (state == ST_IDLE && state_nx != ST_IDLE) begin
        cur_wr   <= head[29];
        dram_bg  <= head[28:27];
        dram_ba  <= head[26:25];
        dram_row <= head[24:10];
        dram_col <= head[9:0];
      end
      rsp_done <= (state == ST_WAIT_DATA) && (state_nx != ST_WAIT_DATA);
    end
  end

  always_comb begin
    cmd_valid = 1'b0;
    dram_cmd  = 3'd0;
    case (state)
      ST_ACT: begin
        cmd_valid = 1'b1;
        dram_cmd  = 3'd1;
      end
      ST_CAS: begin
        cmd_valid = 1'b1;
        dram_cmd  = cur_wr ? 3'd3 : 3'd2;
      end
      ST_PRE: begin
        cmd_valid = 1'b1;
        dram_cmd  = 3'd4;
      end
      default: ;
    endcase
  end

  assign drained = in_done && empty && (state == ST_IDLE);

endmodule

// File: doc/dram_cmd_scheduler.md
DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 16, request queue entries (power of 2).
REQ-002 SHALL have parameter TRCD, default 24, ACT-to-CAS spacing in clocks.
REQ-003 SHALL have parameter TCL, default 24, CAS-to-data-start in clocks.
REQ-004 SHALL have parameter TRP, default 24, PRE-to-ACT spacing in clocks.
REQ-005 SHALL have parameter TBURST, default 4, data burst length in clocks.
REQ-006 SHALL have ports:
- clock  in  1  sole clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present this cycle.
- in_command  in  32  0=read, 1=write, 2=ifetch.
- in_address  in  36  byte address.
- in_done  in  1  trace source exhausted (level).
- full  out  1  queue full.
- empty  out  1  queue empty.
- count  out  $clog2(DEPTH)+1  occupancy.
- cmd_valid  out  1  DRAM command valid this cycle.
- dram_cmd  out  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE.
- dram_bg  out  2  bank group.
- dram_ba  out  2  bank.
- dram_row  out  15  row.
- dram_col  out  10  column.
- rsp_done  out  1  one-cycle pulse, access complete.
- err_drop  out  1  one-cycle pulse, illegal command discarded.
- drained  out  1  in_done high, queue empty, FSM idle.

Function
REQ-007 SHALL decode address: row=addr[32:18], ba=addr[17:16], bg=addr[7:6], col={addr[15:8],addr[5:4]}; addr[35:33], [3:0] ignored.
REQ-008 SHALL enqueue when in_valid && !full && in_command<=2; ifetch stored as read.
REQ-009 SHALL, when in_valid && in_command>2, store nothing and pulse err_drop next cycle.
REQ-010 SHALL ignore in_valid while full, even if a dequeue occurs the same cycle; no overwrite.
REQ-011 SHALL, on simultaneous enqueue and dequeue when not full, leave count unchanged; pointers wrap modulo DEPTH.
REQ-012 SHALL derive full/empty/count from registered state only; no combinational path from in_valid.
REQ-013 SHALL serve requests strictly in order, one at a time.
REQ-014 SHALL implement FSM states IDLE, ACT, WAIT_RCD, CAS, WAIT_DATA, PRE, WAIT_RP; command states last exactly one cycle with cmd_valid=1; all other states drive cmd_valid=0, dram_cmd=0.
REQ-015 SHALL leave IDLE the cycle after empty deasserts.
REQ-016 SHALL issue CAS (RD or WR per head command) exactly TRCD cycles after its ACT, and dequeue the head in the CAS cycle.
REQ-017 SHALL stay in WAIT_DATA TCL+TBURST cycles after CAS, then assert rsp_done for one cycle on the exit transition.
REQ-018 SHALL issue the next ACT no earlier than TRP cycles after any PRE.
REQ-019 SHALL drive dram_bg/ba/row/col from the head entry during ACT, CAS and PRE; otherwise hold last value.
REQ-020 SHALL assert drained combinationally from in_done, empty and state==IDLE.

Reset
REQ-021 SHALL, on reset, empty the queue, enter IDLE, clear all counters and open-row tracking, and drive full=0, empty=1, count=0, cmd_valid=0, dram_cmd=0, addresses=0, rsp_done=0, err_drop=0.
REQ-022 SHALL abort any in-flight access on reset with no PRE issued and no rsp_done pulse.

Configuration
REQ-023 SHALL, with OPEN_PAGE_EN undefined, use closed page: IDLE->ACT->WAIT_RCD->CAS->WAIT_DATA->PRE->WAIT_RP->IDLE, PRE issued the cycle rsp_done pulses.
REQ-024 SHALL, with OPEN_PAGE_EN defined, track one open row per bank (16 banks): hit -> CAS directly from IDLE; closed bank -> ACT; conflict -> PRE, WAIT_RP, ACT; WAIT_DATA exits to IDLE without PRE.
REQ-025 SHALL, with OPEN_PAGE_EN defined, mark a bank open on ACT and closed on PRE.

Verification
REQ-026 Single read addr 0x0_0004_0000, closed page -> ACT row=1, RD TRCD=24 cycles later, rsp_done 28 cycles after RD, PRE same cycle, next ACT >=24 cycles later.
REQ-027 17 writes back-to-back with FSM stalled -> full after 16th, 17th dropped, count=16, no err_drop.
REQ-028 in_command=5 -> err_drop one cycle, count unchanged, no DRAM command.
REQ-029 OPEN_PAGE_EN, two reads same bank/row -> second issues RD with no ACT/PRE; third read same bank, row+1 -> PRE, ACT, RD.
REQ-030 Reset asserted in WAIT_DATA -> next cycle cmd_valid=0, empty=1, no rsp_done; new request then served from ACT.
REQ-031 in_done high with 3 queued -> drained rises only after 3rd rsp_done and FSM back in IDLE.
